// File: rtl/sw_query_loader.sv
// rtl/sw_query_loader.sv - Smith-Waterman query stream parser with two query slots
// Optional SW_QLOAD_STATS_EN adds handshake/drop/stall counters.
module sw_query_loader #(
  parameter int STREAM_W      = 128,
  parameter int BASE_W        = 2,
  parameter int MAX_QUERY_LEN = 64,
  parameter int ID_W          = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            si_valid,
  output logic                            si_rdy,
  input  logic [STREAM_W-1:0]             si_data,
  output logic                            q_valid,
  input  logic                            q_rdy,
  output logic [MAX_QUERY_LEN*BASE_W-1:0] q_bases,
  output logic [15:0]                     q_len,
  output logic [ID_W-1:0]                 q_id,
  output logic [31:0]                     q_ref_len,
  output logic [31:0]                     q_threshold,
  output logic                            q_trunc,
  output logic                            err_pulse
`ifdef SW_QLOAD_STATS_EN
  ,
  output logic [31:0]                     stat_queries,
  output logic [15:0]                     stat_drops,
  output logic [31:0]                     stat_stall
`endif
);

  localparam int SLOT_W = MAX_QUERY_LEN * BASE_W;

  typedef enum logic {S_HDR, S_DATA} state_t;

  state_t            state_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        full_q;
  logic [31:0]       beats_q;
  logic [31:0]       bit_off_q;
  logic              err_q;

  logic [SLOT_W-1:0] bases_q   [2];
  logic [15:0]       len_q     [2];
  logic [ID_W-1:0]   id_q      [2];
  logic [31:0]       ref_len_q [2];
  logic [31:0]       thr_q     [2];
  logic              trunc_q   [2];

  logic [15:0]                hdr_len;
  logic [31:0]                hdr_beats;
  logic                       hdr_fire, data_fire, q_fire;
  logic [31:0]                valid_bits;
  logic [SLOT_W+STREAM_W-1:0] shifted;
  logic [SLOT_W-1:0]          keep_mask;
  logic [SLOT_W-1:0]          bases_d;

  assign si_rdy    = !rst && ((state_q == S_DATA) || !full_q[wr_ptr_q]);
  assign hdr_fire  = si_valid && si_rdy && (state_q == S_HDR);
  assign data_fire = si_valid && si_rdy && (state_q == S_DATA);
  assign q_fire    = q_valid && q_rdy;

  assign hdr_len   = si_data[79:64];
  assign hdr_beats = (32'(hdr_len) * 32'(BASE_W) + 32'(STREAM_W - 1)) / 32'(STREAM_W);

  // Place the beat at its running bit offset and drop bits past the declared length.
  always_comb begin
    valid_bits = 32'(len_q[wr_ptr_q]) * 32'(BASE_W);
    shifted    = {{SLOT_W{1'b0}}, si_data} << bit_off_q;
    keep_mask  = '0;
    for (int i = 0; i < SLOT_W; i++) begin
      keep_mask[i] = (32'(i) < valid_bits);
    end
    bases_d = bases_q[wr_ptr_q] | (shifted[SLOT_W-1:0] & keep_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HDR;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      full_q    <= 2'b00;
      beats_q   <= '0;
      bit_off_q <= '0;
      err_q     <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        bases_q[s]   <= '0;
        len_q[s]     <= '0;
        id_q[s]      <= '0;
        ref_len_q[s] <= '0;
        thr_q[s]     <= '0;
        trunc_q[s]   <= 1'b0;
      end
    end else begin
      err_q <= hdr_fire && (hdr_len == 16'd0);
      if (q_fire) begin
        full_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= ~rd_ptr_q;
      end
      case (state_q)
        S_HDR: begin
          if (hdr_fire && (hdr_len != 16'd0)) begin
            bases_q[wr_ptr_q]   <= '0;
            len_q[wr_ptr_q]     <= (hdr_len > 16'(MAX_QUERY_LEN)) ? 16'(MAX_QUERY_LEN) : hdr_len;
            trunc_q[wr_ptr_q]   <= (hdr_len > 16'(MAX_QUERY_LEN));
            id_q[wr_ptr_q]      <= si_data[32+ID_W-1:32];
            ref_len_q[wr_ptr_q] <= si_data[31:0];
            thr_q[wr_ptr_q]     <= si_data[127:96];
            beats_q             <= hdr_beats;
            bit_off_q           <= '0;
            state_q             <= S_DATA;
          end
        end
        S_DATA: begin
          if (data_fire) begin
            bases_q[wr_ptr_q] <= bases_d;
            beats_q           <= beats_q - 32'd1;
            bit_off_q         <= bit_off_q + 32'(STREAM_W);
            if (beats_q == 32'd1) begin
              full_q[wr_ptr_q] <= 1'b1;
              wr_ptr_q         <= ~wr_ptr_q;
              state_q          <= S_HDR;
            end
          end
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign q_valid     = full_q[rd_ptr_q];
  assign q_bases     = bases_q[rd_ptr_q];
  assign q_len       = len_q[rd_ptr_q];
  assign q_id        = id_q[rd_ptr_q];
  assign q_ref_len   = ref_len_q[rd_ptr_q];
  assign q_threshold = thr_q[rd_ptr_q];
  assign q_trunc     = trunc_q[rd_ptr_q];
  assign err_pulse   = err_q;

`ifdef SW_QLOAD_STATS_EN
  logic [31:0] stat_queries_q;
  logic [15:0] stat_drops_q;
  logic [31:0] stat_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_queries_q <= '0;
      stat_drops_q   <= '0;
      stat_stall_q   <= '0;
    end else begin
      if (q_fire)              stat_queries_q <= stat_queries_q + 32'd1;
      if (err_q)               stat_drops_q   <= stat_drops_q + 16'd1;
      if (si_valid && !si_rdy) stat_stall_q   <= stat_stall_q + 32'd1;
    end
  end

  assign stat_queries = stat_queries_q;
  assign stat_drops   = stat_drops_q;
  assign stat_stall   = stat_stall_q;
`endif

endmodule
